mem_port_arbiter: RTL and testbench

Two-requester arbiter for the single-port synchronous data memory. The CPU load/store/fetch path and a secondary device master share the one memory port, for example a DMA engine or the display reader. CPU has fixed priority. A starvation counter guarantees the device a grant within a bounded number of contested cycles. The block returns read data to the winning requester with a registered valid strobe.

---
 rtl/mem_port_arbiter.sv | 87 ++++++++
 tb/tb_mem_port_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-port synchronous memory: CPU has fixed
// priority, a starvation counter bounds device wait, reads return one cycle later.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,

  input  logic              dev_req,
  input  logic              dev_we,
  input  logic [ADDR_W-1:0] dev_addr,
  input  logic [DATA_W-1:0] dev_wdata,
  output logic              dev_gnt,
  output logic              dev_rvalid,
  output logic [DATA_W-1:0] dev_rdata,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic [1:0] rd_owner_q, rd_owner_d;
  logic       dev_pri;

  assign dev_pri = (wait_cnt_q == MAX_WAIT_C);

  always_comb begin
    cpu_gnt = ~reset & cpu_req & ~(dev_req & dev_pri);
    dev_gnt = ~reset & dev_req & ~cpu_gnt;
  end

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = 1'b0;
    if (cpu_gnt) begin
      mem_we = cpu_we;
    end else if (dev_gnt) begin
      mem_addr  = dev_addr;
      mem_wdata = dev_wdata;
      mem_we    = dev_we;
    end
  end

  // Counter holds while the device is idle so a returning request keeps its priority.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (dev_gnt) begin
      wait_cnt_d = '0;
    end else if (dev_req && (wait_cnt_q < MAX_WAIT_C)) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  assign rd_owner_d = {dev_gnt & ~dev_we, cpu_gnt & ~cpu_we};

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
      rd_owner_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // Gated by reset so a read granted just before reset never reports valid.
  assign cpu_rvalid = rd_owner_q[0] & ~reset;
  assign dev_rvalid = rd_owner_q[1] & ~reset;
  assign cpu_rdata  = mem_rdata;
  assign dev_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written corner
// sequences and a randomized run checked against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dev_req, dev_we;
  logic [15:0] cpu_addr, cpu_wdata, dev_addr, dev_wdata;
  logic        cpu_gnt, cpu_rvalid, dev_gnt, dev_rvalid, mem_we;
  logic [15:0] cpu_rdata, dev_rdata, mem_addr, mem_wdata;
  logic [15:0] mem_rdata;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .dev_gnt(dev_gnt), .dev_rvalid(dev_rvalid), .dev_rdata(dev_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory, preloaded with {a,a} except 0x10 = 0xBEEF.
  logic [15:0] mem [256];
  logic        mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int unsigned i = 0; i < 256; i++) mem[i] <= (i == 16) ? 16'hBEEF : {i[7:0], i[7:0]};
      mem_loaded <= 1'b1;
    end else begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  int    nvec = 0;
  int    nmis = 0;
  int    cyc  = 0;
  string phase = "init";

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s/%s cyc %0d: got %0h expected %0h", phase, name, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic creq, input logic cwe,
                       input logic [15:0] caddr, input logic [15:0] cwd,
                       input logic dreq, input logic dwe,
                       input logic [15:0] daddr, input logic [15:0] dwd);
    @(posedge clk);
    #1;
    reset = rst; cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    dev_req = dreq; dev_we = dwe; dev_addr = daddr; dev_wdata = dwd;
    cyc++;
    #4;
  endtask

  typedef struct {
    logic rst, creq, cwe; logic [15:0] caddr;
    logic dreq, dwe; logic [15:0] daddr, dwd;
    logic egc, egd, ewe; logic [15:0] eaddr, ewd;
    logic ecrv, edrv; logic [15:0] erd;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic creq, input logic cwe,
                              input logic [15:0] caddr, input logic dreq, input logic dwe,
                              input logic [15:0] daddr, input logic [15:0] dwd,
                              input logic gc, input logic gd, input logic we,
                              input logic [15:0] addr, input logic [15:0] wd,
                              input logic crv, input logic drv, input logic [15:0] rd);
    vec_t v;
    v.rst = rst; v.creq = creq; v.cwe = cwe; v.caddr = caddr;
    v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd;
    v.egc = gc; v.egd = gd; v.ewe = we; v.eaddr = addr; v.ewd = wd;
    v.ecrv = crv; v.edrv = drv; v.erd = rd;
    return v;
  endfunction

  // Transaction-level reference state for the random run.
  logic [15:0] ref_mem [256];
  int          ref_wait;
  int          ref_owner;   // 0 none, 1 cpu, 2 device
  logic [15:0] ref_data;

  initial begin
    vec_t tbl [11];
    logic [7:0] dpat, dexp;
    logic cpend, dpend, egc, egd, rst;

    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dev_req = 1'b0; dev_we = 1'b0; dev_addr = '0; dev_wdata = '0;

    //             rst crq cwe caddr  drq dwe daddr  dwd       gc gd we addr   wd       crv drv rd
    tbl[0]  = mk(1, 1, 1, 16'h30, 1, 1, 16'h31, 16'h5555, 0, 0, 0, 16'h30, 16'hAAAA, 0, 0, 16'h0);
    tbl[1]  = mk(1, 1, 1, 16'h30, 1, 1, 16'h31, 16'h5555, 0, 0, 0, 16'h30, 16'hAAAA, 0, 0, 16'h0);
    tbl[2]  = mk(0, 1, 0, 16'h10, 0, 0, 16'h31, 16'h5555, 1, 0, 0, 16'h10, 16'hAAAA, 0, 0, 16'h0);
    tbl[3]  = mk(0, 0, 0, 16'h10, 1, 1, 16'h20, 16'h1234, 0, 1, 1, 16'h20, 16'h1234, 1, 0, 16'hBEEF);
    tbl[4]  = mk(0, 0, 0, 16'h10, 1, 0, 16'h20, 16'h5555, 0, 1, 0, 16'h20, 16'h5555, 0, 0, 16'h0);
    tbl[5]  = mk(0, 1, 0, 16'h01, 0, 0, 16'h20, 16'h5555, 1, 0, 0, 16'h01, 16'hAAAA, 0, 1, 16'h1234);
    tbl[6]  = mk(0, 0, 0, 16'h01, 1, 0, 16'h02, 16'h5555, 0, 1, 0, 16'h02, 16'h5555, 1, 0, 16'h0101);
    tbl[7]  = mk(0, 1, 0, 16'h30, 0, 0, 16'h02, 16'h5555, 1, 0, 0, 16'h30, 16'hAAAA, 0, 1, 16'h0202);
    tbl[8]  = mk(0, 0, 0, 16'h30, 0, 0, 16'h02, 16'h5555, 0, 0, 0, 16'h30, 16'hAAAA, 1, 0, 16'h3030);
    tbl[9]  = mk(0, 0, 0, 16'h30, 1, 0, 16'h31, 16'h5555, 0, 1, 0, 16'h31, 16'h5555, 0, 0, 16'h0);
    tbl[10] = mk(0, 0, 0, 16'h30, 0, 0, 16'h31, 16'h5555, 0, 0, 0, 16'h30, 16'hAAAA, 0, 1, 16'h3131);

    phase = "table";
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].rst, tbl[i].creq, tbl[i].cwe, tbl[i].caddr, 16'hAAAA,
            tbl[i].dreq, tbl[i].dwe, tbl[i].daddr, tbl[i].dwd);
      chk("cpu_gnt", cpu_gnt, tbl[i].egc);
      chk("dev_gnt", dev_gnt, tbl[i].egd);
      chk("mem_we", mem_we, tbl[i].ewe);
      chk("mem_addr", mem_addr, tbl[i].eaddr);
      chk("mem_wdata", mem_wdata, tbl[i].ewd);
      chk("cpu_rvalid", cpu_rvalid, tbl[i].ecrv);
      chk("dev_rvalid", dev_rvalid, tbl[i].edrv);
      if (tbl[i].ecrv) chk("cpu_rdata", cpu_rdata, tbl[i].erd);
      if (tbl[i].edrv) chk("dev_rdata", dev_rdata, tbl[i].erd);
    end

    // Continuous contention: device wins every (MW+1)-th cycle.
    phase = "starve";
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 0, 16'h40, 16'h0, 1, 0, 16'h41, 16'h0);
      chk("dev_gnt", dev_gnt, (i == MW) || (i == 2 * MW + 1));
      chk("cpu_gnt", cpu_gnt, !((i == MW) || (i == 2 * MW + 1)));
      if (i > 0) chk("dev_rvalid", dev_rvalid, (i == MW + 1));
    end

    // Device drops its request mid-wait; accumulated count must be kept.
    phase = "hold";
    dpat = 8'b1110_0011;
    dexp = 8'b1000_0000;
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, 16'h40, 16'h0, dpat[i], 0, 16'h41, 16'h0);
      chk("dev_gnt", dev_gnt, dexp[i]);
    end

    // Reset in the cycle after a CPU read: no rvalid and counter cleared.
    phase = "rst_mid";
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 16'h42, 16'h0, 1, 0, 16'h43, 16'h0);
      chk("cpu_gnt", cpu_gnt, 1'b1);
    end
    drive(1, 1, 1, 16'h42, 16'hDEAD, 1, 1, 16'h43, 16'hDEAD);
    chk("cpu_gnt", cpu_gnt, 1'b0);
    chk("dev_gnt", dev_gnt, 1'b0);
    chk("mem_we", mem_we, 1'b0);
    chk("cpu_rvalid", cpu_rvalid, 1'b0);
    chk("dev_rvalid", dev_rvalid, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 16'h42, 16'h0, 1, 0, 16'h43, 16'h0);
      if (i == 0) chk("cpu_rvalid", cpu_rvalid, 1'b0);
      chk("dev_gnt", dev_gnt, (i == MW));
    end

    // Randomized run on addresses 0x80-0xFF, untouched by earlier phases.
    phase = "random";
    for (int unsigned a = 0; a < 256; a++) ref_mem[a] = {a[7:0], a[7:0]};
    ref_wait = 0; ref_owner = 0; ref_data = '0;
    cpend = 1'b0; dpend = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic        creq_n, cwe_n, dreq_n, dwe_n;
      logic [15:0] caddr_n, cwd_n, daddr_n, dwd_n;
      creq_n = cpu_req; cwe_n = cpu_we; caddr_n = cpu_addr; cwd_n = cpu_wdata;
      dreq_n = dev_req; dwe_n = dev_we; daddr_n = dev_addr; dwd_n = dev_wdata;
      if (!cpend) begin
        creq_n = ($urandom_range(3) != 0);
        cwe_n = $urandom_range(1) == 1;
        caddr_n = 16'($urandom_range(255, 128));
        cwd_n = 16'($urandom);
        cpend = creq_n;
      end
      if (!dpend) begin
        dreq_n = ($urandom_range(3) != 0);
        dwe_n = $urandom_range(1) == 1;
        daddr_n = 16'($urandom_range(255, 128));
        dwd_n = 16'($urandom);
        dpend = dreq_n;
      end
      rst = (i == 0) || ($urandom_range(31) == 0);
      drive(rst, creq_n, cwe_n, caddr_n, cwd_n, dreq_n, dwe_n, daddr_n, dwd_n);

      egc = !rst && creq_n && !(dreq_n && ref_wait == MW);
      egd = !rst && dreq_n && !egc;
      chk("cpu_gnt", cpu_gnt, egc);
      chk("dev_gnt", dev_gnt, egd);
      chk("mem_we", mem_we, (egc && cwe_n) || (egd && dwe_n));
      chk("mem_addr", mem_addr, egd ? daddr_n : caddr_n);
      chk("mem_wdata", mem_wdata, egd ? dwd_n : cwd_n);
      chk("cpu_rvalid", cpu_rvalid, !rst && ref_owner == 1);
      chk("dev_rvalid", dev_rvalid, !rst && ref_owner == 2);
      if (!rst && ref_owner == 1) chk("cpu_rdata", cpu_rdata, ref_data);
      if (!rst && ref_owner == 2) chk("dev_rdata", dev_rdata, ref_data);

      ref_owner = 0;
      if (egc) begin
        cpend = 1'b0;
        if (cwe_n) ref_mem[caddr_n[7:0]] = cwd_n;
        else begin ref_owner = 1; ref_data = ref_mem[caddr_n[7:0]]; end
      end
      if (egd) begin
        dpend = 1'b0;
        if (dwe_n) ref_mem[daddr_n[7:0]] = dwd_n;
        else begin ref_owner = 2; ref_data = ref_mem[daddr_n[7:0]]; end
      end
      if (rst || egd) ref_wait = 0;
      else if (dreq_n && ref_wait < MW) ref_wait++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
